// File: rtl/bias_loader_pkg.sv
// bias_loader_pkg
//   Shared constants for the bias store writer and its users.
//   DATA_W          : width of one bias word (the CNN datapath word length)
//   BIAS_PER_LAYER  : channels per layer (32)
//   BIAS_LAYERS     : layers held in the store (LAYER0..LAYER3, AFFINE = 5)
//   BIAS_NUM        : total store depth (160)
//   LAYER0..AFFINE  : 4-bit layer select codes driven on cs_layer
package bias_loader_pkg;

    localparam int DATA_W         = 16;
    localparam int BIAS_PER_LAYER = 32;
    localparam int BIAS_LAYERS    = 5;
    localparam int BIAS_NUM       = BIAS_PER_LAYER * BIAS_LAYERS;
    localparam int IDX_W          = 8;
    localparam int BUS_W          = BIAS_PER_LAYER * DATA_W;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BIAS_NUM - 1);

    localparam logic [3:0] LAYER0 = 4'd0;
    localparam logic [3:0] LAYER1 = 4'd1;
    localparam logic [3:0] LAYER2 = 4'd2;
    localparam logic [3:0] LAYER3 = 4'd3;
    localparam logic [3:0] AFFINE = 4'd4;

endpackage

// File: rtl/bias_loader.sv
// bias_loader
//   Writer side of the per-channel bias store. After a start pulse it
//   accepts BIAS_NUM words over a valid/ready handshake, word k going to
//   entry k (layer L, channel n lives at 32*L+n, AFFINE is L=4). It also
//   drives the 32 biases of the selected layer as a registered packed bus.
//
// Ports
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset; clears state and the store
//   start      : one-cycle request to begin a full load (ignored while busy)
//   s_valid    : a bias word is present on s_data
//   s_data     : bias word, stored bit-exact
//   s_ready    : word accepted this cycle when s_valid is high
//   busy       : load in progress
//   done       : one-cycle pulse after the final word is accepted
//   bias_valid : the whole store has been written and no load is running
//   cs_layer   : layer select code
//   bias_q     : selected layer's biases, channel n at [n*DATA_W +: DATA_W]
module bias_loader
    import bias_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              busy,
    output logic              done,
    output logic              bias_valid,
    input  logic [3:0]        cs_layer,
    output logic [BUS_W-1:0]  bias_q
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  idx;
    logic              accept;
    logic              last_word;

    logic [DATA_W-1:0] bias [BIAS_NUM];

    logic              layer_ok;
    logic [IDX_W-1:0]  offset;
    logic [BUS_W-1:0]  sel;

    // ------------------------------------------------------------------
    // Control FSM. s_ready is a pure function of state so the upstream
    // source never sees a combinational path from its own s_valid.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        busy       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b1;
                if (s_valid && (idx == LAST_IDX)) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign accept    = s_valid && s_ready;
    assign last_word = (idx == LAST_IDX);

    // Word counter, completion pulse and store-valid flag. The counter is
    // returned to zero on the final accept so it never runs past the store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx        <= '0;
            done       <= 1'b0;
            bias_valid <= 1'b0;
        end else begin
            done <= accept && last_word;
            if ((state == ST_IDLE) && start) begin
                idx        <= '0;
                bias_valid <= 1'b0;
            end else if (accept) begin
                if (last_word) begin
                    idx        <= '0;
                    bias_valid <= 1'b1;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Store. Reset clears every entry so a partial load never leaves
    // stale coefficients behind.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BIAS_NUM; i++) begin
                bias[i] <= '0;
            end
        end else if (accept) begin
            bias[idx] <= s_data;
        end
    end

    // ------------------------------------------------------------------
    // Read path: layer code to store offset, then a registered gather of
    // the 32 consecutive entries. Unknown codes read as all zeros.
    // ------------------------------------------------------------------
    always_comb begin
        layer_ok = 1'b1;
        offset   = '0;
        case (cs_layer)
            LAYER0:  offset = IDX_W'(0 * BIAS_PER_LAYER);
            LAYER1:  offset = IDX_W'(1 * BIAS_PER_LAYER);
            LAYER2:  offset = IDX_W'(2 * BIAS_PER_LAYER);
            LAYER3:  offset = IDX_W'(3 * BIAS_PER_LAYER);
            AFFINE:  offset = IDX_W'(4 * BIAS_PER_LAYER);
            default: layer_ok = 1'b0;
        endcase
    end

    always_comb begin
        sel = '0;
        if (layer_ok) begin
            for (int n = 0; n < BIAS_PER_LAYER; n++) begin
                sel[n*DATA_W +: DATA_W] = bias[offset + IDX_W'(n)];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_q <= '0;
        end else begin
            bias_q <= sel;
        end
    end

endmodule

// File: tb/tb_bias_loader.sv
// tb_bias_loader
//   Directed sequence with randomized data and back-pressure, checked
//   against an array model of the 160-entry store.
module tb_bias_loader;
    import bias_loader_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              start = 1'b0;
    logic              s_valid = 1'b0;
    logic [DATA_W-1:0] s_data = '0;
    logic              s_ready;
    logic              busy;
    logic              done;
    logic              bias_valid;
    logic [3:0]        cs_layer = LAYER0;
    logic [BUS_W-1:0]  bias_q;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] model [BIAS_NUM];
    logic [3:0]        codes [BIAS_LAYERS] = '{LAYER0, LAYER1, LAYER2, LAYER3, AFFINE};

    bias_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .busy       (busy),
        .done       (done),
        .bias_valid (bias_valid),
        .cs_layer   (cs_layer),
        .bias_q     (bias_q)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_bus(input string tag, input logic [BUS_W-1:0] obs, input logic [BUS_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected read bus: layer position in the code list picks 32 entries.
    function automatic logic [BUS_W-1:0] exp_q(input logic [3:0] code);
        logic [BUS_W-1:0] r;
        int lyr;
        r   = '0;
        lyr = -1;
        for (int i = 0; i < BIAS_LAYERS; i++) begin
            if (code == codes[i]) lyr = i;
        end
        if (lyr >= 0) begin
            for (int n = 0; n < BIAS_PER_LAYER; n++) begin
                r[n*DATA_W +: DATA_W] = model[lyr*BIAS_PER_LAYER + n];
            end
        end
        return r;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < BIAS_NUM; i++) model[i] = '0;
    endtask

    task automatic check_all_layers(input string tag);
        for (int i = 0; i < BIAS_LAYERS; i++) begin
            cs_layer = codes[i];
            step();
            check_bus(tag, bias_q, exp_q(codes[i]));
        end
    endtask

    // One load: random_data picks word values, gapped toggles s_valid,
    // restart_at re-pulses start at that word, abort_at pulls reset there,
    // pre_valid holds s_valid high in the start cycle.
    task automatic run_load(input bit random_data, input bit gapped, input int restart_at,
                            input int abort_at, input bit pre_valid);
        logic [DATA_W-1:0] data [BIAS_NUM];
        int k;
        int cycles;
        for (int i = 0; i < BIAS_NUM; i++) begin
            data[i] = random_data ? DATA_W'($urandom) : DATA_W'(i);
        end
        start   = 1'b1;
        s_valid = pre_valid;
        s_data  = 16'hDEAD;
        step();
        start = 1'b0;
        check_bit("load_ready", s_ready, 1'b1);
        check_bit("load_busy", busy, 1'b1);
        check_bit("load_bv_clear", bias_valid, 1'b0);
        k      = 0;
        cycles = 0;
        while (k < BIAS_NUM && cycles < 4 * BIAS_NUM) begin
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                check_bus("abort_bias_q", bias_q, '0);
                check_bit("abort_ready", s_ready, 1'b0);
                check_bit("abort_busy", busy, 1'b0);
                check_bit("abort_done", done, 1'b0);
                check_bit("abort_bv", bias_valid, 1'b0);
                clear_model();
                s_valid = 1'b0;
                step();
                rst_n = 1'b1;
                return;
            end
            s_valid = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = data[k];
            start   = (k == restart_at);
            step();
            cycles++;
            start = 1'b0;
            if (s_valid) begin
                model[k] = data[k];
                k++;
            end
            check_bit("done_timing", done, k == BIAS_NUM);
            if (k < BIAS_NUM) begin
                check_bit("busy_mid", busy, 1'b1);
                check_bit("bv_mid", bias_valid, 1'b0);
            end
        end
        s_valid = 1'b0;
        check_int("load_complete", k, BIAS_NUM);
        if (!gapped) check_int("load_cycles", cycles, BIAS_NUM);
        check_bit("end_busy", busy, 1'b0);
        check_bit("end_ready", s_ready, 1'b0);
        check_bit("end_bv", bias_valid, 1'b1);
        step();
        check_bit("done_drop", done, 1'b0);
        check_bit("bv_hold", bias_valid, 1'b1);
    endtask

    initial begin
        logic [BUS_W-1:0] ramp;

        // Reset state
        #2;
        rst_n = 1'b0;
        #1;
        check_bus("rst_bias_q", bias_q, '0);
        check_bit("rst_ready", s_ready, 1'b0);
        check_bit("rst_busy", busy, 1'b0);
        check_bit("rst_done", done, 1'b0);
        check_bit("rst_bv", bias_valid, 1'b0);
        step();
        rst_n = 1'b1;
        clear_model();

        for (int i = 0; i < BIAS_LAYERS; i++) begin
            cs_layer = codes[i];
            step();
            check_bus("idle_read", bias_q, '0);
            check_bit("idle_ready", s_ready, 1'b0);
            check_bit("idle_bv", bias_valid, 1'b0);
        end

        // Bubble-free ramp load
        run_load(1'b0, 1'b0, -1, -1, 1'b0);
        cs_layer = LAYER2;
        step();
        for (int n = 0; n < BIAS_PER_LAYER; n++) ramp[n*DATA_W +: DATA_W] = DATA_W'(64 + n);
        check_bus("ramp_layer2", bias_q, ramp);
        cs_layer = AFFINE;
        step();
        for (int n = 0; n < BIAS_PER_LAYER; n++) ramp[n*DATA_W +: DATA_W] = DATA_W'(128 + n);
        check_bus("ramp_affine", bias_q, ramp);
        check_all_layers("ramp_all");

        // Same ramp under back-pressure
        run_load(1'b0, 1'b1, -1, -1, 1'b0);
        check_all_layers("gapped_all");

        // Random data, start repeated at word 40, s_valid high in start cycle
        run_load(1'b1, 1'b0, 40, -1, 1'b1);
        check_all_layers("restart_all");

        // Reset at word 50, then a full reload
        run_load(1'b1, 1'b1, -1, 50, 1'b0);
        check_all_layers("abort_all");
        run_load(1'b1, 1'b1, -1, -1, 1'b0);
        check_all_layers("reload_all");

        // Invalid layer code and one-edge select latency
        cs_layer = 4'hF;
        step();
        check_bus("invalid_layer", bias_q, '0);
        cs_layer = LAYER0;
        step();
        check_bus("sel_layer0", bias_q, exp_q(LAYER0));
        cs_layer = LAYER1;
        #1;
        check_bus("sel_hold", bias_q, exp_q(LAYER0));
        step();
        check_bus("sel_layer1", bias_q, exp_q(LAYER1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
